// File: rtl/fetch_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl_pkg
// Brief    : Shared types and constants for the instruction-fetch sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_seq_ctrl_pkg;

  // Instruction word width.
  localparam int INSTR_W = 32;

  // Byte distance between consecutive instructions.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // first cycle after reset release
    ST_REQ   = 2'd1,  // request outstanding at the current pc
    ST_DRAIN = 2'd2,  // squashed request still outstanding at the old address
    ST_HOLD  = 2'd3   // fetched word presented to decode
  } fetch_state_e;

  // Forces an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl_if
// Brief    : Instruction-memory, decode and redirect signals of the fetch
//            sequencer. The master side is the sequencer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_seq_ctrl_if;
  import fetch_seq_ctrl_pkg::*;

  // Instruction memory request/ack
  logic               imem_req;
  logic [31:0]        imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  // Decode valid/ready
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst;
  logic [31:0]        inst_pc;

  // Redirects from execute
  logic               jmpFlag;
  logic [31:0]        jmpAddress;
  logic               branchFlag;
  logic               zeroflag;
  logic [31:0]        branchOffset;
  logic [31:0]        br_pc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  jmpFlag, jmpAddress, branchFlag, zeroflag, branchOffset, br_pc
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output jmpFlag, jmpAddress, branchFlag, zeroflag, branchOffset, br_pc
  );

endinterface
`default_nettype wire

// File: rtl/fetch_seq_ctrl_pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : pc_target_calc
// Brief    : Combinational redirect target: aligned jump address, or
//            br_pc + 4 + (offset << 2) for a branch. Wraps modulo 2^32.
// Revision : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import fetch_seq_ctrl_pkg::*;
(
  input  wire logic        jmp_flag,
  input  wire logic [31:0] jmp_address,
  input  wire logic [31:0] br_pc,
  input  wire logic [31:0] branch_offset,
  output logic      [31:0] target
);

  logic [31:0] w_branch_target;

  // Branch offset is in words; the shift drops the top two offset bits on purpose.
  always_comb begin
    w_branch_target = br_pc + PC_STEP + (branch_offset << 2);
  end

  // Jump wins over a branch resolving in the same cycle.
  always_comb begin
    target = jmp_flag ? align_word(jmp_address) : w_branch_target;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq_ctrl
// Brief    : Instruction-fetch sequencer. Owns the pc, fetches through a
//            req/ack memory port, presents words to decode over valid/ready
//            and applies jump / taken-branch redirects.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,  // must be word aligned
  parameter int unsigned TIMEOUT  = 16              // 0 disables the watchdog
) (
  input  wire logic         clk,
  input  wire logic         rst,        // asynchronous, active low
  fetch_seq_ctrl_if.master  bus,
  output logic       [31:0] pc,
  output logic              fetch_err
);

  localparam int          CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic        WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  fetch_state_e       r_state;
  logic [31:0]        r_pc;
  logic [31:0]        r_addr;      // address of the outstanding request
  logic               r_req;
  logic               r_hold;
  logic [INSTR_W-1:0] r_inst;
  logic [31:0]        r_inst_pc;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic               r_err;

  logic               w_redirect;
  logic [31:0]        w_target;
  logic [31:0]        w_next_fetch;
  logic [CNT_W-1:0]   w_cnt_inc;

  pc_target_calc u_target (
    .jmp_flag      (bus.jmpFlag),
    .jmp_address   (bus.jmpAddress),
    .br_pc         (bus.br_pc),
    .branch_offset (bus.branchOffset),
    .target        (w_target)
  );

  // Redirect decode and the address the next fetch should use.
  always_comb begin
    w_redirect   = bus.jmpFlag | (bus.branchFlag & bus.zeroflag);
    w_next_fetch = w_redirect ? w_target : r_pc;
    w_cnt_inc    = r_wait_cnt + CNT_W'(1);
  end

  // Fetch FSM: pc, request, held instruction. imem_addr only moves when a new request starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_addr    <= RESET_PC;
      r_req     <= 1'b0;
      r_hold    <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
          r_req   <= 1'b1;
          r_pc    <= w_next_fetch;
          r_addr  <= w_next_fetch;
        end

        ST_REQ: begin
          if (bus.imem_ack) begin
            if (w_redirect) begin
              // Returned word belongs to the squashed path: refetch at target.
              r_pc   <= w_target;
              r_addr <= w_target;
            end else begin
              r_state   <= ST_HOLD;
              r_req     <= 1'b0;
              r_hold    <= 1'b1;
              r_inst    <= bus.imem_rdata;
              r_inst_pc <= r_pc;
              r_pc      <= r_pc + PC_STEP;
            end
          end else if (w_redirect) begin
            // Request cannot be withdrawn; wait it out at the old address.
            r_state <= ST_DRAIN;
            r_pc    <= w_target;
          end
        end

        ST_DRAIN: begin
          if (bus.imem_ack) begin
            r_state <= ST_REQ;
            r_addr  <= w_next_fetch;
          end
          if (w_redirect) begin
            r_pc <= w_target;
          end
        end

        ST_HOLD: begin
          if (w_redirect) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_hold  <= 1'b0;
            r_pc    <= w_target;
            r_addr  <= w_target;
          end else if (bus.inst_ready) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_hold  <= 1'b0;
            r_addr  <= r_pc;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_req   <= 1'b0;
          r_hold  <= 1'b0;
        end
      endcase
    end
  end

  // Watchdog: counts unacknowledged request cycles, saturates, sets a sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else if (r_req) begin
      if (bus.imem_ack) begin
        r_wait_cnt <= '0;
      end else if (WDOG_EN && (r_wait_cnt != CNT_LIMIT)) begin
        r_wait_cnt <= w_cnt_inc;
        if (w_cnt_inc == CNT_LIMIT) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Outputs; valid is gated so decode never accepts a word being squashed.
  always_comb begin
    bus.imem_req   = r_req;
    bus.imem_addr  = r_addr;
    bus.inst_valid = r_hold & ~w_redirect;
    bus.inst       = r_inst;
    bus.inst_pc    = r_inst_pc;
    pc             = r_pc;
    fetch_err      = r_err;
  end

endmodule
`default_nettype wire
